// File: rtl/iq_frame_averager.sv
// iq_frame_averager
//
// AXI-Stream sink that averages fixed-length complex I/Q frames. Each input beat carries
// {real[31:16], imag[15:0]} as signed 16-bit lanes. A frame of exactly 2^FRAME_LOG2 beats,
// closed by tlast on the last beat, produces one averaged {real, imag} word on the master
// port. Frames that end early, or run past N beats, are discarded and flagged on frame_error.
//
// Optional build macro:
//   IQ_AVG_ROUND_EN  defined   -> round half-up (add 2^(FRAME_LOG2-1) before the shift)
//                    undefined -> truncate toward negative infinity (plain >>>)
//
// Ports:
//   s00_axis_aclk    clock for both interfaces
//   s00_axis_areset  synchronous reset, active-high
//   s00_axis_tdata   input sample {real, imag}, two's complement
//   s00_axis_tstrb   ignored
//   s00_axis_tvalid  input beat valid
//   s00_axis_tlast   last beat of frame
//   s00_axis_tready  input ready (low only while an average waits for its handshake)
//   m00_axis_tdata   averaged {real, imag}
//   m00_axis_tstrb   constant 4'hF
//   m00_axis_tvalid  output word valid
//   m00_axis_tlast   same as m00_axis_tvalid (one-beat frames)
//   m00_axis_tready  downstream ready
//   frame_error      one-cycle pulse when a frame of the wrong length is discarded

module iq_frame_averager #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int FRAME_LOG2             = 4
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_areset,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
   input  logic                                s00_axis_tvalid,
   input  logic                                s00_axis_tlast,
   output logic                                s00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
   output logic                                m00_axis_tvalid,
   output logic                                m00_axis_tlast,
   input  logic                                m00_axis_tready,
   output logic                                frame_error
);

   // Accumulator width: 16-bit lanes summed over 2^FRAME_LOG2 beats cannot overflow.
   localparam int AW = 16 + FRAME_LOG2;

   localparam logic [1:0] StAccum  = 2'd0;
   localparam logic [1:0] StOutput = 2'd1;
   localparam logic [1:0] StDrain  = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [FRAME_LOG2-1:0]   cnt_q, cnt_d;
   logic signed [AW-1:0]    acc_re_q, acc_re_d;
   logic signed [AW-1:0]    acc_im_q, acc_im_d;
   logic [31:0]             out_q, out_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;

   logic signed [AW-1:0]    in_re, in_im;
   logic signed [AW-1:0]    sum_re, sum_im;
   logic [15:0]             avg_re, avg_im;
   logic                    last_cnt;

   logic unused_tstrb;
   assign unused_tstrb = ^s00_axis_tstrb;

   // Sign-extend each 16-bit lane to accumulator width.
   assign in_re = {{FRAME_LOG2{s00_axis_tdata[31]}}, s00_axis_tdata[31:16]};
   assign in_im = {{FRAME_LOG2{s00_axis_tdata[15]}}, s00_axis_tdata[15:0]};

   // Sums that include the beat currently presented; used both for accumulation and for
   // forming the average on the final beat.
   assign sum_re = acc_re_q + in_re;
   assign sum_im = acc_im_q + in_im;

`ifdef IQ_AVG_ROUND_EN
   localparam logic signed [AW-1:0] RoundK = AW'(1) << (FRAME_LOG2 - 1);

   logic signed [AW-1:0] rnd_re, rnd_im;

   // Headroom: 32767*N + N/2 still fits in AW signed bits, so no saturation is needed.
   assign rnd_re = sum_re + RoundK;
   assign rnd_im = sum_im + RoundK;
   assign avg_re = 16'(rnd_re >>> FRAME_LOG2);
   assign avg_im = 16'(rnd_im >>> FRAME_LOG2);
`else
   assign avg_re = 16'(sum_re >>> FRAME_LOG2);
   assign avg_im = 16'(sum_im >>> FRAME_LOG2);
`endif

   // Count of N-1 means the presented beat is the N-th of the frame.
   assign last_cnt = &cnt_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      out_d    = out_q;
      valid_d  = valid_q;
      err_d    = 1'b0;

      case (state_q)
         StAccum: begin
            if (s00_axis_tvalid) begin
               if (last_cnt) begin
                  acc_re_d = '0;
                  acc_im_d = '0;
                  cnt_d    = '0;
                  if (s00_axis_tlast) begin
                     out_d   = {avg_re, avg_im};
                     valid_d = 1'b1;
                     state_d = StOutput;
                  end else begin
                     // Frame too long: drop the rest up to its tlast.
                     err_d   = 1'b1;
                     state_d = StDrain;
                  end
               end else if (s00_axis_tlast) begin
                  // Frame too short: drop it and start fresh.
                  err_d    = 1'b1;
                  acc_re_d = '0;
                  acc_im_d = '0;
                  cnt_d    = '0;
               end else begin
                  acc_re_d = sum_re;
                  acc_im_d = sum_im;
                  cnt_d    = cnt_q + 1'b1;
               end
            end
         end

         StOutput: begin
            if (m00_axis_tready) begin
               valid_d = 1'b0;
               state_d = StAccum;
            end
         end

         StDrain: begin
            if (s00_axis_tvalid && s00_axis_tlast) begin
               state_d = StAccum;
            end
         end

         default: begin
            state_d = StAccum;
         end
      endcase
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         state_q  <= StAccum;
         cnt_q    <= '0;
         acc_re_q <= '0;
         acc_im_q <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   // Input is refused only while an averaged word is waiting to be taken.
   assign s00_axis_tready = (state_q != StOutput);

   assign m00_axis_tdata  = out_q;
   assign m00_axis_tstrb  = '1;
   assign m00_axis_tvalid = valid_q;
   assign m00_axis_tlast  = valid_q;
   assign frame_error     = err_q;

endmodule

// File: tb/tb_iq_frame_averager.sv
module tb_iq_frame_averager;

   localparam int L = 2;
   localparam int N = 1 << L;

   logic        clk = 1'b0;
   logic        areset;
   logic [31:0] s_tdata;
   logic [3:0]  s_tstrb;
   logic        s_tvalid, s_tlast, s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic        m_tvalid, m_tlast, m_tready;
   logic        frame_error;

   int total = 0;
   int bad = 0;
   int timeouts = 0;

   logic [31:0] got_q[$];
   int          err_pulses = 0;
   int          stall_viol = 0;
   logic        hold_prev = 1'b0;
   logic [31:0] data_prev = '0;
   logic        rand_rdy = 1'b0;

   iq_frame_averager #(
      .C_S00_AXIS_TDATA_WIDTH(32),
      .C_M00_AXIS_TDATA_WIDTH(32),
      .FRAME_LOG2(L)
   ) dut (
      .s00_axis_aclk  (clk),
      .s00_axis_areset(areset),
      .s00_axis_tdata (s_tdata),
      .s00_axis_tstrb (s_tstrb),
      .s00_axis_tvalid(s_tvalid),
      .s00_axis_tlast (s_tlast),
      .s00_axis_tready(s_tready),
      .m00_axis_tdata (m_tdata),
      .m00_axis_tstrb (m_tstrb),
      .m00_axis_tvalid(m_tvalid),
      .m00_axis_tlast (m_tlast),
      .m00_axis_tready(m_tready),
      .frame_error    (frame_error)
   );

   always #5 clk = ~clk;

   // Observer, sampled mid-cycle: output handshakes, error pulses, hold-rule violations.
   always @(negedge clk) begin
      if (!areset) begin
         if (hold_prev && (m_tvalid !== 1'b1 || m_tdata !== data_prev)) stall_viol++;
         if (m_tvalid === 1'b1 && m_tready === 1'b1) got_q.push_back(m_tdata);
         if (frame_error === 1'b1) err_pulses++;
      end
      hold_prev = m_tvalid && !m_tready && !areset;
      data_prev = m_tdata;
   end

   // Random downstream backpressure when enabled.
   always @(posedge clk) begin
      #2;
      if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
   end

   // Reference: mean of the frame's lanes, rounded as the build selects.
   function automatic logic [15:0] lane_avg(input int s);
      int q;
`ifdef IQ_AVG_ROUND_EN
      s = s + N / 2;
`endif
      q = s / N;
      if ((s % N) != 0 && s < 0) q = q - 1;
      return 16'(q);
   endfunction

   function automatic logic [31:0] model_avg(input logic [31:0] b[$]);
      int sr = 0;
      int si = 0;
      foreach (b[i]) begin
         sr += int'($signed(b[i][31:16]));
         si += int'($signed(b[i][15:0]));
      end
      return {lane_avg(sr), lane_avg(si)};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat and return one step after its handshake edge.
   task automatic send_beat(input logic [31:0] d, input logic last);
      bit ok = 0;
      s_tdata  = d;
      s_tlast  = last;
      s_tstrb  = 4'($urandom);
      s_tvalid = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         if (s_tready === 1'b1) begin
            ok = 1;
            break;
         end
         idle(1);
      end
      if (ok) idle(1);
      else timeouts++;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_out(input int n);
      for (int k = 0; k < 500 && got_q.size() < n; k++) idle(1);
   endtask

   task automatic test_reset;
      areset   = 1'b1;
      s_tvalid = 1'b1;
      s_tlast  = 1'b1;
      s_tdata  = $urandom;
      m_tready = 1'b1;
      idle(3);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      areset   = 1'b0;
      total++;
      if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b expected 1", s_tready); end
      total++;
      if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
      total++;
      if (m_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata: got %h expected 0", m_tdata); end
      total++;
      if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", frame_error); end
      total++;
      if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b expected 0", m_tlast); end
      total++;
      if (m_tstrb !== 4'hF) begin bad++; $display("FAIL reset_tstrb: got %h expected f", m_tstrb); end
      got_q.delete();
      err_pulses = 0;
   endtask

   task automatic test_basic;
      int re_v[4] = '{100, 200, 300, 403};
      int im_v[4] = '{-1, -2, -3, -4};
      logic [31:0] exp;
`ifdef IQ_AVG_ROUND_EN
      exp = {16'd251, 16'hFFFE};
`else
      exp = {16'd250, 16'hFFFD};
`endif
      got_q.delete();
      err_pulses = 0;
      m_tready = 1'b1;
      for (int i = 0; i < N; i++) send_beat({16'(re_v[i]), 16'(im_v[i])}, i == N - 1);
      total++;
      if (m_tvalid !== 1'b1) begin bad++; $display("FAIL basic_latency: tvalid %b expected 1", m_tvalid); end
      total++;
      if (m_tdata !== exp) begin bad++; $display("FAIL basic_data: got %h expected %h", m_tdata, exp); end
      total++;
      if (m_tlast !== 1'b1) begin bad++; $display("FAIL basic_tlast: got %b expected 1", m_tlast); end
      idle(2);
      total++;
      if (got_q.size() !== 1) begin bad++; $display("FAIL basic_count: got %0d expected 1", got_q.size()); end
      total++;
      if (err_pulses !== 0) begin bad++; $display("FAIL basic_err: got %0d expected 0", err_pulses); end
   endtask

   task automatic test_extremes;
      logic [31:0] pat[2] = '{32'h7FFF7FFF, 32'h80008000};
      m_tready = 1'b1;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < N; i++) send_beat(pat[p], i == N - 1);
         total++;
         if (m_tvalid !== 1'b1 || m_tdata !== pat[p]) begin
            bad++;
            $display("FAIL extreme_%0d: got v=%b d=%h expected v=1 d=%h", p, m_tvalid, m_tdata, pat[p]);
         end
         idle(1);
      end
   endtask

   task automatic test_early_tlast;
      got_q.delete();
      err_pulses = 0;
      m_tready = 1'b1;
      for (int i = 0; i < N - 1; i++) send_beat($urandom, i == N - 2);
      total++;
      if (frame_error !== 1'b1) begin bad++; $display("FAIL early_pulse: got %b expected 1", frame_error); end
      idle(1);
      total++;
      if (frame_error !== 1'b0) begin bad++; $display("FAIL early_pulse_width: got %b expected 0", frame_error); end
      idle(3);
      total++;
      if (got_q.size() !== 0) begin bad++; $display("FAIL early_no_output: got %0d expected 0", got_q.size()); end
      total++;
      if (err_pulses !== 1) begin bad++; $display("FAIL early_err_count: got %0d expected 1", err_pulses); end
      for (int i = 0; i < N; i++) send_beat(32'h00100020, i == N - 1);
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h00100020) begin
         bad++;
         $display("FAIL early_next: got v=%b d=%h expected v=1 d=00100020", m_tvalid, m_tdata);
      end
      idle(1);
   endtask

   task automatic test_long_frame;
      logic [31:0] beats[$];
      logic [31:0] exp;
      got_q.delete();
      err_pulses = 0;
      m_tready = 1'b1;
      for (int i = 0; i < N + 2; i++) begin
         total++;
         if (s_tready !== 1'b1) begin bad++; $display("FAIL long_tready_%0d: got %b expected 1", i, s_tready); end
         send_beat($urandom, i == N + 1);
         if (i == N - 1) begin
            total++;
            if (frame_error !== 1'b1) begin bad++; $display("FAIL long_pulse: got %b expected 1", frame_error); end
         end
      end
      idle(3);
      total++;
      if (err_pulses !== 1) begin bad++; $display("FAIL long_err_count: got %0d expected 1", err_pulses); end
      total++;
      if (got_q.size() !== 0) begin bad++; $display("FAIL long_no_output: got %0d expected 0", got_q.size()); end
      for (int i = 0; i < N; i++) begin
         beats.push_back($urandom);
         send_beat(beats[i], i == N - 1);
      end
      exp = model_avg(beats);
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp) begin
         bad++;
         $display("FAIL long_next: got v=%b d=%h expected v=1 d=%h", m_tvalid, m_tdata, exp);
      end
      idle(1);
   endtask

   task automatic test_backpressure;
      logic [31:0] beats[$];
      logic [31:0] exp;
      got_q.delete();
      m_tready = 1'b0;
      for (int i = 0; i < N; i++) begin
         beats.push_back($urandom);
         send_beat(beats[i], i == N - 1);
      end
      exp = model_avg(beats);
      for (int c = 0; c < 10; c++) begin
         total++;
         if (m_tvalid !== 1'b1 || m_tdata !== exp || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold_%0d: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=0",
                     c, m_tvalid, m_tdata, s_tready, exp);
         end
         idle(1);
      end
      m_tready = 1'b1;
      idle(1);
      total++;
      if (m_tvalid !== 1'b0) begin bad++; $display("FAIL bp_release_tvalid: got %b expected 0", m_tvalid); end
      total++;
      if (s_tready !== 1'b1) begin bad++; $display("FAIL bp_release_tready: got %b expected 1", s_tready); end
      total++;
      if (got_q.size() !== 1 || got_q[0] !== exp) begin
         bad++;
         $display("FAIL bp_handshake: got n=%0d expected n=1 d=%h", got_q.size(), exp);
      end
   endtask

   task automatic test_reset_mid;
      got_q.delete();
      err_pulses = 0;
      m_tready = 1'b1;
      send_beat(32'h7FFF7FFF, 1'b0);
      send_beat(32'h7FFF7FFF, 1'b0);
      areset = 1'b1;
      idle(1);
      areset = 1'b0;
      total++;
      if (m_tvalid !== 1'b0 || frame_error !== 1'b0 || s_tready !== 1'b1) begin
         bad++;
         $display("FAIL midrst_state: got v=%b err=%b rdy=%b expected 0 0 1", m_tvalid, frame_error, s_tready);
      end
      for (int i = 0; i < N; i++) send_beat(32'h00040004, i == N - 1);
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h00040004) begin
         bad++;
         $display("FAIL midrst_next: got v=%b d=%h expected v=1 d=00040004", m_tvalid, m_tdata);
      end
      idle(2);
      total++;
      if (err_pulses !== 0) begin bad++; $display("FAIL midrst_err: got %0d expected 0", err_pulses); end
   endtask

   task automatic test_random;
      logic [31:0] exp_q[$];
      int exp_err = 0;
      got_q.delete();
      err_pulses = 0;
      stall_viol = 0;
      rand_rdy = 1'b1;
      for (int f = 0; f < 30; f++) begin
         logic [31:0] beats[$];
         int len = ($urandom_range(0, 9) < 6) ? N : int'($urandom_range(1, N + 3));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            beats.push_back($urandom);
            send_beat(beats[i], i == len - 1);
         end
         if (len == N) exp_q.push_back(model_avg(beats));
         else exp_err++;
      end
      wait_out(exp_q.size());
      idle(3);
      rand_rdy = 1'b0;
      m_tready = 1'b1;
      idle(2);
      total++;
      if (got_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rand_word_%0d: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      total++;
      if (err_pulses !== exp_err) begin bad++; $display("FAIL rand_err: got %0d expected %0d", err_pulses, exp_err); end
      total++;
      if (stall_viol !== 0) begin bad++; $display("FAIL rand_hold: got %0d violations expected 0", stall_viol); end
   endtask

   task automatic test_no_timeouts;
      total++;
      if (timeouts !== 0) begin bad++; $display("FAIL handshake_timeout: got %0d expected 0", timeouts); end
   endtask

   initial begin
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      s_tstrb  = '0;
      m_tready = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_extremes();
      test_early_tlast();
      test_long_frame();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_no_timeouts();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
